// File: rtl/block_move_ctrl.sv
// Moving-block overlay motion controller: prescaled motion steps committed at frame start,
// bouncing between the border bounds, with a valid/ready port to place the block directly.
module block_move_ctrl #(
    parameter int H_DISP    = 1920,
    parameter int V_DISP    = 1080,
    parameter int VIDEO_CLK = 148500000,
    parameter int BLOCK_CLK = 100,
    parameter int SIDE_W    = 40,
    parameter int BLOCK_W   = 80,
    parameter int STEP      = 1
) (
    input  logic        pixel_clk_i,
    input  logic        sys_rst_i,
    input  logic        video_vs_i,
    input  logic        move_en_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [10:0] cfg_x_i,
    input  logic [10:0] cfg_y_i,
    input  logic [1:0]  cfg_dir_i,
    output logic [10:0] block_x_o,
    output logic [10:0] block_y_o,
    output logic        dir_x_o,
    output logic        dir_y_o,
    output logic        pos_update_o,
    output logic        busy_o
);

    localparam int P     = VIDEO_CLK / BLOCK_CLK;
    localparam int CNT_W = (P > 1) ? $clog2(P) : 1;

    localparam logic [10:0] X_MIN  = 11'(SIDE_W);
    localparam logic [10:0] Y_MIN  = 11'(SIDE_W);
    localparam logic [10:0] X_MAX  = 11'(H_DISP - SIDE_W - BLOCK_W);
    localparam logic [10:0] Y_MAX  = 11'(V_DISP - SIDE_W - BLOCK_W);
    localparam logic [10:0] STEP_W = 11'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CALC, S_COMMIT} state_t;

    state_t             state_q, state_d;
    logic               vs_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d, pend_clr;
    logic [10:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [10:0]        nxt_x_q, nxt_x_d, nxt_y_q, nxt_y_d;
    logic               nxt_dx_q, nxt_dx_d, nxt_dy_q, nxt_dy_d;
    logic               upd_q, upd_d;
    logic               rdy_q, rdy_d;
    logic               vs_rise, tick, cfg_acc, in_commit;

    // One axis step in 12 bits; returns {new_dir, new_pos}, pinned to [mn, mx].
    function automatic logic [11:0] step_axis(input logic [10:0] p, input logic dir,
                                              input logic [10:0] mn, input logic [10:0] mx);
        logic [11:0] up;
        up = {1'b0, p} + {1'b0, STEP_W};
        if (dir) begin
            if (up >= {1'b0, mx}) return {1'b0, mx};
            return {1'b1, up[10:0]};
        end
        if ({1'b0, p} <= {1'b0, mn} + {1'b0, STEP_W}) return {1'b1, mn};
        return {1'b0, p - STEP_W};
    endfunction

    function automatic logic [10:0] clamp(input logic [10:0] v, input logic [10:0] mn,
                                          input logic [10:0] mx);
        if (v < mn) return mn;
        if (v > mx) return mx;
        return v;
    endfunction

    assign vs_rise = video_vs_i & ~vs_q;
    assign tick    = move_en_i && (cnt_q == CNT_W'(P - 1));
    assign cfg_acc = cfg_valid_i & rdy_q;

    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        nxt_x_d  = nxt_x_q;
        nxt_y_d  = nxt_y_q;
        nxt_dx_d = nxt_dx_q;
        nxt_dy_d = nxt_dy_q;
        upd_d    = 1'b0;
        pend_clr = 1'b0;

        unique case (state_q)
            S_IDLE, S_WAIT: begin
                if (cfg_acc) begin
                    // Placement wins over a same-cycle frame start; that frame's step is dropped.
                    pos_x_d  = clamp(cfg_x_i, X_MIN, X_MAX);
                    pos_y_d  = clamp(cfg_y_i, Y_MIN, Y_MAX);
                    dir_x_d  = cfg_dir_i[0];
                    dir_y_d  = cfg_dir_i[1];
                    upd_d    = 1'b1;
                    pend_clr = 1'b1;
                end else if (state_q == S_IDLE) begin
                    if (move_en_i) state_d = S_WAIT;
                end else if (!move_en_i) begin
                    state_d = S_IDLE;
                end else if (pend_q && vs_rise) begin
                    state_d  = S_CALC;
                    pend_clr = 1'b1;
                end
            end
            S_CALC: begin
                {nxt_dx_d, nxt_x_d} = step_axis(pos_x_q, dir_x_q, X_MIN, X_MAX);
                {nxt_dy_d, nxt_y_d} = step_axis(pos_y_q, dir_y_q, Y_MIN, Y_MAX);
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                pos_x_d = nxt_x_q;
                pos_y_d = nxt_y_q;
                dir_x_d = nxt_dx_q;
                dir_y_d = nxt_dy_q;
                state_d = move_en_i ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!move_en_i)    pend_d = 1'b0;
        else if (tick)     pend_d = 1'b1;
        else if (pend_clr) pend_d = 1'b0;
        else               pend_d = pend_q;

        if (!move_en_i || tick) cnt_d = '0;
        else                    cnt_d = cnt_q + CNT_W'(1);

        rdy_d = (state_d == S_IDLE) || (state_d == S_WAIT);
    end

    always_ff @(posedge pixel_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q  <= S_IDLE;
            vs_q     <= 1'b0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            pos_x_q  <= X_MIN;
            pos_y_q  <= Y_MIN;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            nxt_x_q  <= X_MIN;
            nxt_y_q  <= Y_MIN;
            nxt_dx_q <= 1'b1;
            nxt_dy_q <= 1'b1;
            upd_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vs_q     <= video_vs_i;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            nxt_x_q  <= nxt_x_d;
            nxt_y_q  <= nxt_y_d;
            nxt_dx_q <= nxt_dx_d;
            nxt_dy_q <= nxt_dy_d;
            upd_q    <= upd_d;
            rdy_q    <= rdy_d;
        end
    end

    // The computed step is presented throughout COMMIT and becomes the stored position at its end.
    assign in_commit    = (state_q == S_COMMIT);
    assign block_x_o    = in_commit ? nxt_x_q  : pos_x_q;
    assign block_y_o    = in_commit ? nxt_y_q  : pos_y_q;
    assign dir_x_o      = in_commit ? nxt_dx_q : dir_x_q;
    assign dir_y_o      = in_commit ? nxt_dy_q : dir_y_q;
    assign pos_update_o = upd_q | in_commit;
    assign busy_o       = (state_q == S_CALC) || in_commit;
    assign cfg_ready_o  = rdy_q;

endmodule
